// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding read on an AXI-lite style bus,
// started at boot or by a WBU fetch_en pulse, result handed to the IDU.
module ifu_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_ifu_npc,
  input  logic              i_ifu_fetch_en,
  output logic [ADDR_W-1:0] o_ifu_araddr,
  output logic              o_ifu_arvalid,
  input  logic              i_ifu_arready,
  input  logic [INST_W-1:0] i_ifu_rdata,
  input  logic [1:0]        i_ifu_rresp,
  input  logic              i_ifu_rvalid,
  output logic              o_ifu_rready,
  output logic [INST_W-1:0] o_ifu_inst,
  output logic [ADDR_W-1:0] o_ifu_pc,
  output logic              o_ifu_valid,
  input  logic              i_ifu_ready,
  output logic              o_ifu_err,
  output logic              o_ifu_overrun
);

  // state | meaning
  // IDLE  | waiting for boot flag or fetch_en
  // AR    | read address presented, waiting for arready
  // R     | waiting for read data
  // OUT   | instruction presented to IDU, waiting for ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e            state_q;
  logic              boot_q;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic              err_q;
  logic              overrun_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              valid_q;

  logic              start;
  logic              misaligned;

  assign start      = boot_q | i_ifu_fetch_en;
  assign misaligned = (i_ifu_npc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      boot_q    <= 1'b1;
      pc_q      <= '0;
      inst_q    <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      // Any fetch_en outside IDLE is dropped, including one coinciding with the OUT handshake.
      if (i_ifu_fetch_en && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            boot_q <= 1'b0;
            pc_q   <= i_ifu_npc;
            if (misaligned) begin
              state_q <= S_OUT;
              inst_q  <= '0;
              err_q   <= 1'b1;
              valid_q <= 1'b1;
            end else begin
              state_q   <= S_AR;
              err_q     <= 1'b0;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (i_ifu_arready) begin
            state_q   <= S_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        S_R: begin
          if (i_ifu_rvalid) begin
            state_q  <= S_OUT;
            rready_q <= 1'b0;
            inst_q   <= i_ifu_rdata;
            err_q    <= (i_ifu_rresp != 2'b00);
            valid_q  <= 1'b1;
          end
        end
        S_OUT: begin
          if (i_ifu_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ifu_araddr  = pc_q;
  assign o_ifu_pc      = pc_q;
  assign o_ifu_inst    = inst_q;
  assign o_ifu_err     = err_q;
  assign o_ifu_overrun = overrun_q;
  assign o_ifu_arvalid = arvalid_q;
  assign o_ifu_rready  = rready_q;
  assign o_ifu_valid   = valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: expected instructions are queued when a fetch
// is driven and checked when o_ifu_valid rises.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_ifu_npc;
  logic        i_ifu_fetch_en;
  logic [31:0] o_ifu_araddr;
  logic        o_ifu_arvalid;
  logic        i_ifu_arready;
  logic [31:0] i_ifu_rdata;
  logic [1:0]  i_ifu_rresp;
  logic        i_ifu_rvalid;
  logic        o_ifu_rready;
  logic [31:0] o_ifu_inst;
  logic [31:0] o_ifu_pc;
  logic        o_ifu_valid;
  logic        i_ifu_ready;
  logic        o_ifu_err;
  logic        o_ifu_overrun;

  ifu_fetch #(.ADDR_W(32), .INST_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_ifu_npc      (i_ifu_npc),
    .i_ifu_fetch_en (i_ifu_fetch_en),
    .o_ifu_araddr   (o_ifu_araddr),
    .o_ifu_arvalid  (o_ifu_arvalid),
    .i_ifu_arready  (i_ifu_arready),
    .i_ifu_rdata    (i_ifu_rdata),
    .i_ifu_rresp    (i_ifu_rresp),
    .i_ifu_rvalid   (i_ifu_rvalid),
    .o_ifu_rready   (o_ifu_rready),
    .o_ifu_inst     (o_ifu_inst),
    .o_ifu_pc       (o_ifu_pc),
    .o_ifu_valid    (o_ifu_valid),
    .i_ifu_ready    (i_ifu_ready),
    .o_ifu_err      (o_ifu_err),
    .o_ifu_overrun  (o_ifu_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ar_hs  = 0;
  int   r_hs   = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (o_ifu_arvalid && i_ifu_arready) ar_hs <= ar_hs + 1;
      if (o_ifu_rready && i_ifu_rvalid)   r_hs  <= r_hs + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_arvalid"}, o_ifu_arvalid, 0);
    chk({tag, "_rready"},  o_ifu_rready, 0);
    chk({tag, "_valid"},   o_ifu_valid, 0);
    chk({tag, "_err"},     o_ifu_err, 0);
    chk({tag, "_overrun"}, o_ifu_overrun, 0);
    chk({tag, "_araddr"},  o_ifu_araddr, 0);
    chk({tag, "_pc"},      o_ifu_pc, 0);
    chk({tag, "_inst"},    o_ifu_inst, 0);
  endtask

  task automatic wait_out(output int waited, output exp_t cur);
    waited = 0;
    while (o_ifu_valid !== 1'b1 && waited < 20) begin
      tick;
      waited++;
    end
    chk("out_valid", o_ifu_valid, 1);
    cur = '0;
    if (sb.size() > 0) cur = sb.pop_front();
    else chk("sb_nonempty", sb.size(), 1);
    chk("out_inst", o_ifu_inst, cur.inst);
    chk("out_pc",   o_ifu_pc,   cur.pc);
    chk("out_err",  o_ifu_err,  cur.err);
  endtask

  // One complete fetch starting from IDLE; delays are bus/IDU stall cycles.
  task automatic do_fetch(input logic [31:0] npc, input logic [31:0] rdata,
                          input logic [1:0] rresp, input int ar_wait,
                          input int r_wait, input int out_wait, input bit use_en,
                          input bit en_in_r, input bit en_at_hs);
    int   ar0, r0, waited;
    bit   mis;
    exp_t e;
    mis = (npc[1:0] != 2'b00);
    ar0 = ar_hs;
    r0  = r_hs;
    e.inst = mis ? 32'h0 : rdata;
    e.pc   = npc;
    e.err  = mis || (rresp != 2'b00);
    sb.push_back(e);
    i_ifu_npc = npc;
    i_ifu_fetch_en = use_en;
    tick;
    i_ifu_fetch_en = 1'b0;
    if (!mis) begin
      for (int i = 0; i < ar_wait; i++) begin
        chk("ar_hold_valid", o_ifu_arvalid, 1);
        chk("ar_hold_addr",  o_ifu_araddr, npc);
        tick;
      end
      chk("ar_valid", o_ifu_arvalid, 1);
      chk("ar_addr",  o_ifu_araddr, npc);
      i_ifu_arready = 1'b1;
      tick;
      i_ifu_arready = 1'b0;
      chk("r_ready",       o_ifu_rready, 1);
      chk("r_arvalid_low", o_ifu_arvalid, 0);
      for (int i = 0; i < r_wait; i++) begin
        chk("r_hold_ready", o_ifu_rready, 1);
        chk("r_hold_addr",  o_ifu_araddr, npc);
        if (en_in_r && i == 0) begin
          i_ifu_fetch_en = 1'b1;
          i_ifu_npc = npc ^ 32'h0000_0ff0;
        end
        tick;
        i_ifu_fetch_en = 1'b0;
        i_ifu_npc = npc;
      end
      if (en_in_r) begin
        chk("overrun_set",     o_ifu_overrun, 1);
        chk("overrun_pc_kept", o_ifu_pc, npc);
      end
      i_ifu_rvalid = 1'b1;
      i_ifu_rdata  = rdata;
      i_ifu_rresp  = rresp;
      tick;
      i_ifu_rvalid = 1'b0;
      i_ifu_rresp  = 2'b00;
    end else begin
      chk("mis_no_arvalid", o_ifu_arvalid, 0);
    end
    wait_out(waited, e);
    if (ar_wait == 0 && r_wait == 0) chk("latency", waited, 0);
    for (int i = 0; i < out_wait; i++) begin
      tick;
      chk("out_hold_valid", o_ifu_valid, 1);
      chk("out_hold_inst",  o_ifu_inst, e.inst);
      chk("out_hold_pc",    o_ifu_pc, e.pc);
      chk("out_hold_err",   o_ifu_err, e.err);
    end
    i_ifu_ready = 1'b1;
    i_ifu_fetch_en = en_at_hs;
    tick;
    i_ifu_ready = 1'b0;
    i_ifu_fetch_en = 1'b0;
    chk("out_done", o_ifu_valid, 0);
    chk("ar_hs_count", ar_hs - ar0, mis ? 0 : 1);
    chk("r_hs_count",  r_hs - r0,   mis ? 0 : 1);
    if (en_at_hs) begin
      chk("hs_overrun", o_ifu_overrun, 1);
      tick;
      chk("hs_no_start", o_ifu_arvalid, 0);
      chk("hs_pc_kept",  o_ifu_pc, npc);
    end
  endtask

  initial begin
    int   waited;
    exp_t e;
    rst = 1'b1;
    i_ifu_npc = 32'h8000_0000;
    i_ifu_fetch_en = 1'b0;
    i_ifu_arready = 1'b0;
    i_ifu_rdata = 32'h0;
    i_ifu_rresp = 2'b00;
    i_ifu_rvalid = 1'b0;
    i_ifu_ready = 1'b0;
    repeat (3) tick;
    chk_reset("reset");

    // Boot without fetch_en, minimum latency.
    rst = 1'b0;
    do_fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("boot_no_overrun", o_ifu_overrun, 0);

    do_fetch(32'h8000_0004, 32'h0010_0093, 2'b00, 0, 0, 0, 1, 0, 0);
    do_fetch(32'h8000_0008, 32'h0020_8133, 2'b00, 3, 4, 2, 1, 0, 0);
    do_fetch(32'h8000_000c, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 1, 0, 0);
    do_fetch(32'h8000_0010, 32'h0000_0013, 2'b00, 0, 0, 0, 1, 0, 0);
    do_fetch(32'h8000_0002, 32'h1234_5678, 2'b00, 0, 0, 1, 1, 0, 0);
    do_fetch(32'h8000_0014, 32'h00A0_0513, 2'b00, 1, 2, 0, 1, 1, 0);
    do_fetch(32'h8000_0018, 32'h00B0_0593, 2'b00, 0, 0, 0, 1, 0, 0);
    chk("overrun_sticky", o_ifu_overrun, 1);

    // Reset while in R, then a late rvalid.
    i_ifu_npc = 32'h8000_0020;
    i_ifu_fetch_en = 1'b1;
    tick;
    i_ifu_fetch_en = 1'b0;
    i_ifu_arready = 1'b1;
    tick;
    i_ifu_arready = 1'b0;
    chk("mid_in_r", o_ifu_rready, 1);
    rst = 1'b1;
    i_ifu_npc = 32'h8000_0000;
    tick;
    chk_reset("midrst");
    rst = 1'b0;
    i_ifu_rvalid = 1'b1;
    i_ifu_rdata = 32'hBAD0_BAD0;
    chk("late_rv_rready", o_ifu_rready, 0);
    chk("late_rv_valid",  o_ifu_valid, 0);
    tick;
    chk("late_rv_ar_valid",  o_ifu_arvalid, 1);
    chk("late_rv_ar_addr",   o_ifu_araddr, 32'h8000_0000);
    chk("late_rv_ar_rready", o_ifu_rready, 0);
    chk("late_rv_ar_out",    o_ifu_valid, 0);
    i_ifu_rvalid = 1'b0;
    i_ifu_arready = 1'b1;
    tick;
    i_ifu_arready = 1'b0;
    chk("reboot_rready", o_ifu_rready, 1);
    e.inst = 32'h0000_0413;
    e.pc   = 32'h8000_0000;
    e.err  = 1'b0;
    sb.push_back(e);
    i_ifu_rvalid = 1'b1;
    i_ifu_rdata = 32'h0000_0413;
    tick;
    i_ifu_rvalid = 1'b0;
    wait_out(waited, e);
    chk("reboot_latency", waited, 0);
    i_ifu_ready = 1'b1;
    tick;
    i_ifu_ready = 1'b0;
    chk("reboot_done", o_ifu_valid, 0);

    // fetch_en coinciding with the OUT handshake.
    chk("pre_hs_overrun", o_ifu_overrun, 0);
    do_fetch(32'h8000_0030, 32'h0030_0193, 2'b00, 0, 0, 0, 1, 0, 1);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
